tt_um_count_checker: RTL and testbench

Receive-side partner of the team's free-running 8-bit counter source. Samples an incoming 8-bit count stream on ui_in and checks that each valid sample is the previous sample +1 (mod 256). Locks onto the stream, counts sequence errors, and reports lock and error status on the TT output pins. Used on the board or tester end to qualify a counter-emitting tile's output bus.

---
 rtl/tt_um_count_checker.sv | 132 +++++++++++++
 tb/tb_tt_um_count_checker.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/tt_um_count_checker.sv
// Count-stream checker: locks onto an incrementing 8-bit stream on ui_in,
// flywheels through isolated glitches once locked, and counts sequence errors.
module tt_um_count_checker #(
  parameter int unsigned LOCK_N = 4,
  parameter int unsigned LOSS_N = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    SYNC   = 2'd1,
    LOCKED = 2'd2,
    SPARE  = 2'd3
  } state_t;

  localparam logic [3:0] LOCK_CNT = 4'(LOCK_N);
  localparam logic [3:0] LOSS_CNT = 4'(LOSS_N);

  state_t      state;
  logic [7:0]  exp;
  logic [3:0]  good_cnt;
  logic [3:0]  bad_run;
  logic [7:0]  err_cnt;
  logic        err_pulse;

  logic        valid;
  logic        clr_err;
  logic        out_sel;
  logic [7:0]  exp_next;
  logic        match;
  logic [3:0]  good_inc;
  logic [3:0]  bad_inc;
  logic        count_err;
  logic [7:0]  err_inc;
  logic        unused_ok;

  assign valid     = uio_in[0];
  assign clr_err   = uio_in[1];
  assign out_sel   = uio_in[2];
  assign unused_ok = &{1'b0, ena, uio_in[7:3]};

  // Increment compare wraps naturally at 8 bits, so 0xFF -> 0x00 matches.
  assign exp_next  = exp + 8'd1;
  assign match     = (ui_in == exp_next);
  assign good_inc  = good_cnt + 4'd1;
  assign bad_inc   = bad_run + 4'd1;

  // Only mismatches while locked are errors; SYNC just re-anchors silently.
  assign count_err = valid && (state == LOCKED) && !match;
  assign err_inc   = (err_cnt == 8'hFF) ? err_cnt : err_cnt + 8'd1;

  // Lock/anchor state machine and the one-cycle error strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= HUNT;
      exp       <= '0;
      good_cnt  <= '0;
      bad_run   <= '0;
      err_pulse <= 1'b0;
    end else begin
      err_pulse <= 1'b0;
      if (valid) begin
        case (state)
          HUNT: begin
            exp      <= ui_in;
            good_cnt <= '0;
            state    <= SYNC;
          end
          SYNC: begin
            exp <= ui_in;
            if (match) begin
              good_cnt <= good_inc;
              if (good_inc == LOCK_CNT) begin
                state   <= LOCKED;
                bad_run <= '0;
              end
            end else begin
              good_cnt <= '0;
            end
          end
          LOCKED: begin
            if (match) begin
              exp     <= ui_in;
              bad_run <= '0;
            end else begin
              err_pulse <= 1'b1;
              bad_run   <= bad_inc;
              // Too many misses in a row: give up the flywheel and re-anchor.
              if (bad_inc == LOSS_CNT) begin
                state    <= SYNC;
                exp      <= ui_in;
                good_cnt <= '0;
              end else begin
                exp <= exp_next;
              end
            end
          end
          default: state <= HUNT;
        endcase
      end else if (state == SPARE) begin
        state <= HUNT;
      end
    end
  end

  // Saturating error counter; a clear wins over a same-cycle increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt <= '0;
    end else if (clr_err) begin
      err_cnt <= '0;
    end else if (count_err) begin
      err_cnt <= err_inc;
    end
  end

  // Output pin mapping; out_sel steers uo_out combinationally.
  always_comb begin
    uo_out  = out_sel ? exp : err_cnt;
    uio_out = {(state == HUNT), (err_cnt == 8'hFF), err_pulse, (state == LOCKED), 4'b0000};
    uio_oe  = 8'hF0;
  end

endmodule

// File: tb/tb_tt_um_count_checker.sv
// Self-checking bench for tt_um_count_checker: directed scenarios with literal
// expectations plus a randomized stream checked against a behavioural model.
module tb_tt_um_count_checker;

  localparam int LOCK_N = 4;
  localparam int LOSS_N = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b1;
  logic [7:0] ui_in = 8'h00;
  logic [7:0] uio_in = 8'h00;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int n_cmp = 0;
  int n_bad = 0;
  bit check_en = 1'b0;

  tt_um_count_checker #(.LOCK_N(LOCK_N), .LOSS_N(LOSS_N)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in), .uio_in(uio_in),
    .uo_out(uo_out), .uio_out(uio_out), .uio_oe(uio_oe)
  );

  always #5 clk = ~clk;

  // Behavioural model: mode names and plain integer arithmetic.
  string m_mode = "HUNT";
  int    m_exp = 0, m_good = 0, m_bad = 0, m_err = 0;
  bit    m_pulse = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    bit hit;
    if (!rst_n) begin
      m_mode = "HUNT"; m_exp = 0; m_good = 0; m_bad = 0; m_err = 0; m_pulse = 1'b0;
    end else begin
      hit = (int'(ui_in) == (m_exp + 1) % 256);
      m_pulse = 1'b0;
      if (uio_in[0]) begin
        if (m_mode == "HUNT") begin
          m_exp = int'(ui_in); m_good = 0; m_mode = "SYNC";
        end else if (m_mode == "SYNC") begin
          m_exp = int'(ui_in);
          if (hit) begin
            m_good = m_good + 1;
            if (m_good == LOCK_N) begin m_mode = "LOCK"; m_bad = 0; end
          end else m_good = 0;
        end else begin
          if (hit) begin
            m_exp = int'(ui_in); m_bad = 0;
          end else begin
            m_bad = m_bad + 1;
            m_err = (m_err < 255) ? m_err + 1 : 255;
            m_pulse = 1'b1;
            if (m_bad == LOSS_N) begin
              m_mode = "SYNC"; m_exp = int'(ui_in); m_good = 0;
            end else m_exp = (m_exp + 1) % 256;
          end
        end
      end
      if (uio_in[1]) m_err = 0;
    end
  end

  // Compare DUT outputs with the model on every falling edge.
  always @(negedge clk) begin
    logic [7:0] e_uo, e_uio;
    if (check_en) begin
      e_uo  = uio_in[2] ? 8'(m_exp) : 8'(m_err);
      e_uio = {(m_mode == "HUNT"), (m_err == 255), m_pulse, (m_mode == "LOCK"), 4'b0000};
      n_cmp = n_cmp + 3;
      if (uo_out !== e_uo) begin
        n_bad = n_bad + 1;
        $display("FAIL model_uo_out t=%0t got=%02h want=%02h", $time, uo_out, e_uo);
      end
      if (uio_out !== e_uio) begin
        n_bad = n_bad + 1;
        $display("FAIL model_uio_out t=%0t got=%02h want=%02h", $time, uio_out, e_uio);
      end
      if (uio_oe !== 8'hF0) begin
        n_bad = n_bad + 1;
        $display("FAIL model_uio_oe t=%0t got=%02h want=f0", $time, uio_oe);
      end
    end
  end

  task automatic chk(input string name, input int act, input int want);
    n_cmp = n_cmp + 1;
    if (act != want) begin
      n_bad = n_bad + 1;
      $display("FAIL %s got=%02h want=%02h", name, act, want);
    end
  endtask

  // One clock: apply inputs, wait for the edge, settle 1 time unit.
  task automatic cyc(input bit v, input logic [7:0] d, input bit clr, input bit sel);
    ui_in  = d;
    uio_in = {5'b00000, sel, clr, v};
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cyc(1'b0, 8'h00, 1'b0, 1'b0);
    cyc(1'b0, 8'h00, 1'b0, 1'b0);
    rst_n = 1'b1;
    cyc(1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  // From HUNT: anchor on v-LOCK_N, then LOCK_N increments ending at v.
  task automatic lock_to(input logic [7:0] v);
    for (int i = LOCK_N; i >= 0; i--) cyc(1'b1, v - 8'(i), 1'b0, 1'b0);
  endtask

  initial begin
    logic [7:0] e;
    logic [7:0] cur;
    // 1: reset values, and release with valid low
    rst_n = 1'b0;
    @(posedge clk); #1;
    check_en = 1'b1;
    chk("rst_uo_out", int'(uo_out), 8'h00);
    chk("rst_uio_out", int'(uio_out), 8'h80);
    chk("rst_uio_oe", int'(uio_oe), 8'hF0);
    rst_n = 1'b1;
    repeat (3) cyc(1'b0, 8'h55, 1'b0, 1'b0);
    chk("idle_uo_out", int'(uo_out), 8'h00);
    chk("idle_uio_out", int'(uio_out), 8'h80);

    // 2: acquisition on 10..14
    cyc(1'b1, 8'd10, 1'b0, 1'b0);
    chk("acq_hunt_drop", int'(uio_out), 8'h00);
    cyc(1'b1, 8'd11, 1'b0, 1'b0);
    cyc(1'b1, 8'd12, 1'b0, 1'b0);
    cyc(1'b1, 8'd13, 1'b0, 1'b0);
    chk("acq_not_yet_locked", int'(uio_out), 8'h00);
    cyc(1'b1, 8'd14, 1'b0, 1'b0);
    chk("acq_locked", int'(uio_out), 8'h10);
    chk("acq_err_cnt", int'(uo_out), 8'h00);

    // 3: wrap through 0xFF -> 0x00 with gaps
    do_reset();
    lock_to(8'hFC);
    cyc(1'b1, 8'hFD, 1'b0, 1'b0);
    cyc(1'b0, 8'h33, 1'b0, 1'b0);
    cyc(1'b1, 8'hFE, 1'b0, 1'b0);
    cyc(1'b1, 8'hFF, 1'b0, 1'b0);
    cyc(1'b0, 8'h44, 1'b0, 1'b0);
    cyc(1'b0, 8'h44, 1'b0, 1'b0);
    cyc(1'b1, 8'h00, 1'b0, 1'b0);
    chk("wrap_status", int'(uio_out), 8'h10);
    cyc(1'b1, 8'h01, 1'b0, 1'b1);
    chk("wrap_exp", int'(uo_out), 8'h01);
    chk("wrap_status2", int'(uio_out), 8'h10);
    cyc(1'b0, 8'h00, 1'b0, 1'b0);
    chk("wrap_err_cnt", int'(uo_out), 8'h00);

    // 4: single glitch flywheeled
    do_reset();
    lock_to(8'd20);
    cyc(1'b1, 8'd21, 1'b0, 1'b0);
    cyc(1'b1, 8'd99, 1'b0, 1'b0);
    chk("glitch_pulse", int'(uio_out), 8'h30);
    chk("glitch_err_cnt", int'(uo_out), 8'h01);
    cyc(1'b1, 8'd23, 1'b0, 1'b1);
    chk("glitch_flywheel_exp", int'(uo_out), 8'd23);
    chk("glitch_pulse_gone", int'(uio_out), 8'h10);
    cyc(1'b1, 8'd24, 1'b0, 1'b0);
    chk("glitch_err_hold", int'(uo_out), 8'h01);

    // 5: loss of lock after LOSS_N misses, then re-lock
    do_reset();
    lock_to(8'd30);
    cyc(1'b1, 8'd200, 1'b0, 1'b0);
    chk("loss_still_locked", int'(uio_out), 8'h30);
    cyc(1'b1, 8'd201, 1'b0, 1'b0);
    cyc(1'b1, 8'd202, 1'b0, 1'b1);
    chk("loss_status", int'(uio_out), 8'h20);
    chk("loss_exp", int'(uo_out), 8'd202);
    cyc(1'b0, 8'h00, 1'b0, 1'b0);
    chk("loss_err_cnt", int'(uo_out), 8'h03);
    for (int i = 203; i <= 206; i++) cyc(1'b1, 8'(i), 1'b0, 1'b0);
    chk("relock_status", int'(uio_out), 8'h10);

    // 6: clear priority, saturation, reset mid-lock
    do_reset();
    lock_to(8'd40);
    cyc(1'b1, 8'd77, 1'b1, 1'b0);
    chk("clr_err_cnt", int'(uo_out), 8'h00);
    chk("clr_pulse", int'(uio_out), 8'h30);
    cyc(1'b1, 8'd42, 1'b0, 1'b0);
    e = 8'd42;
    for (int i = 0; i < 130; i++) begin
      cyc(1'b1, e + 8'd50, 1'b0, 1'b0); e = e + 8'd1;
      cyc(1'b1, e + 8'd50, 1'b0, 1'b0); e = e + 8'd1;
      cyc(1'b1, e + 8'd1, 1'b0, 1'b0);  e = e + 8'd1;
    end
    chk("sat_err_cnt", int'(uo_out), 8'hFF);
    chk("sat_status", int'(uio_out), 8'h50);
    rst_n = 1'b0;
    #1;
    chk("midlock_reset", int'(uio_out), 8'h80);
    chk("midlock_reset_uo", int'(uo_out), 8'h00);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Random stream: mostly increments, with glitches, gaps, clears and resets
    cur = 8'($urandom);
    for (int i = 0; i < 4000; i++) begin
      bit v, clr, sel;
      logic [7:0] d;
      v   = ($urandom_range(0, 99) < 75);
      sel = $urandom_range(0, 1) == 1;
      clr = v && ($urandom_range(0, 99) < 3);
      if (v) begin
        cur = ($urandom_range(0, 99) < 85) ? cur + 8'd1 : 8'($urandom);
        d = cur;
      end else d = 8'($urandom);
      rst_n = ($urandom_range(0, 999) >= 3);
      cyc(v, d, clr, sel);
    end
    rst_n = 1'b1;
    cyc(1'b0, 8'h00, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
